lcd_pattern_scanner: RTL

// Parametrised test-pattern source for the PMOD LCD path. Scans a H_PIXELS x V_PIXELS

---
 rtl/lcd_pattern_scanner.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_pattern_scanner.sv
// Raster test-pattern source for the PMOD LCD: scans an H_PIXELS x V_PIXELS frame and
// streams RGB565 pixels over valid/ready. Optional macro LCD_FRAME_CRC_EN adds a frame CRC.
module lcd_pattern_scanner #(
    parameter int unsigned H_PIXELS        = 160,
    parameter int unsigned V_PIXELS        = 80,
    parameter int unsigned NUM_MODES       = 9,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    localparam int unsigned HW = $clog2(H_PIXELS),
    localparam int unsigned VW = $clog2(V_PIXELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sw_rstn,
    input  logic          pix_ready,
    output logic          pix_valid,
    output logic [15:0]   pix_data,
    output logic [HW-1:0] H_pos,
    output logic [VW-1:0] V_pos,
    output logic [3:0]    mode,
    output logic          frame_start,
    output logic          frame_done,
    output logic [15:0]   frame_crc
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [HW+2:0] H_DIV = H_PIXELS[HW+2:0];
    localparam logic [VW+4:0] V_DIV = V_PIXELS[VW+4:0];

    typedef enum logic [1:0] {StIdle, StStart, StStream, StDone} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [3:0]    mode_q, mode_d;
    logic          pending_q, pending_d;
    logic [15:0]   pix_q, pix_d;

    logic          sw_meta_q, sw_sync_q;
    logic [DW-1:0] low_cnt_q, low_cnt_d;
    logic [1:0]    high_cnt_q, high_cnt_d;
    logic          armed_q, armed_d;
    logic          press;

    logic          handshake, last_h, last_v;
    logic [HW+2:0] h_prod;
    logic [VW+4:0] v_prod;
    logic [2:0]    bar;
    logic [4:0]    ramp;

    assign handshake = (state_q == StStream) && pix_ready;
    assign last_h    = (h_q == HW'(H_PIXELS - 1));
    assign last_v    = (v_q == VW'(V_PIXELS - 1));

    // One accepted press per low period; re-armed only after two synchronised high cycles.
    always_comb begin
        low_cnt_d  = low_cnt_q;
        high_cnt_d = high_cnt_q;
        armed_d    = armed_q;
        press      = 1'b0;
        if (!sw_sync_q) begin
            high_cnt_d = '0;
            if (armed_q) begin
                if (low_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    press     = 1'b1;
                    armed_d   = 1'b0;
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
        end else begin
            low_cnt_d = '0;
            if (!armed_q) begin
                if (high_cnt_q == 2'd1) begin
                    armed_d    = 1'b1;
                    high_cnt_d = '0;
                end else begin
                    high_cnt_d = high_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        mode_d    = mode_q;
        pending_d = pending_q | press;
        unique case (state_q)
            StIdle: state_d = StStart;
            StStart: begin
                h_d     = '0;
                v_d     = '0;
                state_d = StStream;
                if (pending_q) begin
                    mode_d    = (mode_q == 4'(NUM_MODES - 1)) ? 4'd0 : mode_q + 4'd1;
                    pending_d = 1'b0;
                end
            end
            StStream: begin
                if (handshake) begin
                    if (last_h) begin
                        h_d = '0;
                        if (last_v) begin
                            v_d     = '0;
                            state_d = StDone;
                        end else begin
                            v_d = v_q + 1'b1;
                        end
                    end else begin
                        h_d = h_q + 1'b1;
                    end
                end
            end
            StDone: state_d = StStart;
            default: state_d = StIdle;
        endcase
    end

    // Pixel is computed from next-state position/mode so the register always matches them.
    always_comb begin
        h_prod = {h_d, 3'b000};
        v_prod = {v_d, 5'b00000};
        bar    = 3'(h_prod / H_DIV);
        ramp   = 5'(v_prod / V_DIV);
        pix_d  = 16'h0000;
        case (mode_d)
            4'd1: pix_d = 16'hF800;
            4'd2: pix_d = 16'h07E0;
            4'd3: pix_d = 16'h001F;
            4'd4: pix_d = 16'hFFFF;
            4'd5: pix_d = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
            4'd6: pix_d = {ramp, 11'd0};
            4'd7: pix_d = (((16'(h_d) ^ 16'(v_d)) & 16'h0008) != 16'h0000) ? 16'hFFFF : 16'h0000;
            4'd8: begin
                if (h_d == '0 || h_d == HW'(H_PIXELS - 1) || v_d == '0 ||
                    v_d == VW'(V_PIXELS - 1)) begin
                    pix_d = 16'hFFFF;
                end
            end
            default: pix_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            h_q        <= '0;
            v_q        <= '0;
            mode_q     <= '0;
            pending_q  <= 1'b0;
            pix_q      <= '0;
            sw_meta_q  <= 1'b1;
            sw_sync_q  <= 1'b1;
            low_cnt_q  <= '0;
            high_cnt_q <= '0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
            pix_q      <= pix_d;
            sw_meta_q  <= sw_rstn;
            sw_sync_q  <= sw_meta_q;
            low_cnt_q  <= low_cnt_d;
            high_cnt_q <= high_cnt_d;
            armed_q    <= armed_d;
        end
    end

    assign pix_valid   = (state_q == StStream);
    assign frame_start = (state_q == StStart);
    assign frame_done  = (state_q == StDone);
    assign pix_data    = pix_q;
    assign H_pos       = h_q;
    assign V_pos       = v_q;
    assign mode        = mode_q;

`ifdef LCD_FRAME_CRC_EN
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] crc_acc_q, crc_acc_d, crc_out_q, crc_out_d, crc_next;

    // Result lands on the last handshake so it is already visible during frame_done.
    always_comb begin
        crc_next  = crc16_step(crc_acc_q, pix_q);
        crc_acc_d = crc_acc_q;
        crc_out_d = crc_out_q;
        if (state_q == StStart) begin
            crc_acc_d = 16'hFFFF;
        end else if (handshake) begin
            crc_acc_d = crc_next;
            if (last_h && last_v) crc_out_d = crc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_acc_q <= 16'hFFFF;
            crc_out_q <= 16'h0000;
        end else begin
            crc_acc_q <= crc_acc_d;
            crc_out_q <= crc_out_d;
        end
    end

    assign frame_crc = crc_out_q;
`else
    assign frame_crc = 16'h0000;
`endif

endmodule
